// File: rtl/glitch_filter_pkg.sv
// ---------------------------------------------------------------------------
// glitch_filter_pkg
//   Shared types and constants for the glitch filter and its synchronizer.
//   - gf_state_t     : filter FSM states (stable low/high, pending high/low)
//   - GF_SYNC_MIN/MAX: bounds for the synchronizer depth
//   - gf_clamp_stages: folds an out-of-range synchronizer depth into range
// ---------------------------------------------------------------------------
package glitch_filter_pkg;

  typedef enum logic [1:0] {
    ST_LO      = 2'b00,
    ST_PEND_HI = 2'b01,
    ST_HI      = 2'b10,
    ST_PEND_LO = 2'b11
  } gf_state_t;

  localparam int GF_SYNC_MIN = 2;
  localparam int GF_SYNC_MAX = 4;

  // A single flop gives no metastability protection, and more than four adds
  // latency with no practical benefit, so the depth is held inside [2,4].
  function automatic int gf_clamp_stages(input int stages);
    if (stages < GF_SYNC_MIN) return GF_SYNC_MIN;
    if (stages > GF_SYNC_MAX) return GF_SYNC_MAX;
    return stages;
  endfunction

endpackage

// File: rtl/glitch_filter_if.sv
// ---------------------------------------------------------------------------
// glitch_filter_if
//   Signal bundle between a glitch filter and its user.
//   din        raw asynchronous input
//   clr_cnt    synchronous clear of glitch_cnt
//   dout       filtered level
//   rise/fall  1-cycle strobes on accepted dout edges
//   glitch     1-cycle strobe when a pending transition is rejected
//   glitch_cnt saturating count of rejected pulses
//   master: the user side (drives din/clr_cnt); slave: the filter.
// ---------------------------------------------------------------------------
interface glitch_filter_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             clr_cnt;
  logic             dout;
  logic             rise;
  logic             fall;
  logic             glitch;
  logic [CNT_W-1:0] glitch_cnt;

  modport master (
    output din, clr_cnt,
    input  dout, rise, fall, glitch, glitch_cnt
  );

  modport slave (
    input  din, clr_cnt,
    output dout, rise, fall, glitch, glitch_cnt
  );
endinterface

// File: rtl/glitch_filter_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchronizer for a single asynchronous bit. Reusable for any
//   asynchronous input of the clk domain.
//   clk   system clock, rising edge
//   reset asynchronous active-high reset, clears every stage
//   d     asynchronous input
//   q     synchronized output (last stage)
// ---------------------------------------------------------------------------
module sync_chain
  import glitch_filter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N = gf_clamp_stages(STAGES);

  logic [N-1:0] stage_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[N-2:0], d};
    end
  end

  assign q = stage_reg[N-1];

endmodule

// File: rtl/glitch_filter.sv
// ---------------------------------------------------------------------------
// glitch_filter
//   Synchronizes a raw asynchronous level and only accepts a new level after
//   MIN_WIDTH consecutive samples at that level. Shorter pulses are rejected,
//   strobed on glitch and counted in a saturating counter.
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    glitch_filter_if.slave: din, clr_cnt in; dout, rise, fall,
//          glitch, glitch_cnt out
// ---------------------------------------------------------------------------
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  glitch_filter_if.slave bus
);

  localparam int              CW       = $clog2(MIN_WIDTH + 1);
  // The counter holds the number of samples already seen at the new level,
  // so the MIN_WIDTH-th sample arrives while it reads MIN_WIDTH-1.
  localparam logic [CW-1:0]   CNT_LAST = CW'(MIN_WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] GCNT_MAX = '1;

  logic s;

  gf_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dout_reg, dout_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             glitch_reg, glitch_next;
  logic [CNT_W-1:0] glitch_cnt_reg, glitch_cnt_next;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.din),
    .q    (s)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dout_next   = dout_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    glitch_next = 1'b0;

    case (state_reg)
      ST_LO: begin
        dout_next = 1'b0;
        if (s) begin
          state_next = ST_PEND_HI;
          cnt_next   = CNT_ONE;
        end
      end

      ST_PEND_HI: begin
        if (s) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_HI;
            dout_next  = 1'b1;
            rise_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
          state_next  = ST_LO;
          glitch_next = 1'b1;
          cnt_next    = '0;
        end
      end

      ST_HI: begin
        dout_next = 1'b1;
        if (!s) begin
          state_next = ST_PEND_LO;
          cnt_next   = CNT_ONE;
        end
      end

      ST_PEND_LO: begin
        if (!s) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_LO;
            dout_next  = 1'b0;
            fall_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
          state_next  = ST_HI;
          glitch_next = 1'b1;
          cnt_next    = '0;
        end
      end

      // Any corrupted encoding falls back to a known-low filter.
      default: begin
        state_next = ST_LO;
        dout_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // Clear wins over a coincident glitch; the count never wraps.
  always_comb begin
    glitch_cnt_next = glitch_cnt_reg;
    if (bus.clr_cnt) begin
      glitch_cnt_next = '0;
    end else if (glitch_next && (glitch_cnt_reg != GCNT_MAX)) begin
      glitch_cnt_next = glitch_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_LO;
      cnt_reg        <= '0;
      dout_reg       <= 1'b0;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
      glitch_reg     <= 1'b0;
      glitch_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= dout_next;
      rise_reg       <= rise_next;
      fall_reg       <= fall_next;
      glitch_reg     <= glitch_next;
      glitch_cnt_reg <= glitch_cnt_next;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.rise       = rise_reg;
  assign bus.fall       = fall_reg;
  assign bus.glitch     = glitch_reg;
  assign bus.glitch_cnt = glitch_cnt_reg;

endmodule

// File: doc/glitch_filter.md
Name: glitch_filter

Overview:
- Synchronous consumer for hazard-prone combinational nets such as a 4-input SOP with per-gate delays.
- Samples an asynchronous raw signal and synchronizes it.
- Rejects pulses shorter than a programmable number of clock cycles.
- Outputs a clean level, 1-cycle edge strobes and a saturating count of rejected glitches, for lab benches and debug.

Parameters:
- SYNC_STAGES, 2: number of flops in the input synchronizer; legal range 2 to 4.
- MIN_WIDTH, 4: consecutive clock samples at a new level required before it is accepted; legal range 2 to 255.
- CNT_W, 8: width of the glitch counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  raw asynchronous signal, e.g. a combinational hazard output.
- clr_cnt  input  1  synchronous clear of glitch_cnt.
- dout  output  1  filtered level.
- rise  output  1  1-cycle strobe when dout goes 0->1.
- fall  output  1  1-cycle strobe when dout goes 1->0.
- glitch  output  1  1-cycle strobe when a pending transition is rejected.
- glitch_cnt  output  CNT_W  number of rejected pulses, saturating.

Behaviour:
- Reset (asynchronous assert, synchronous-clean deassert):
  - All synchronizer flops = 0.
  - State = ST_LO, stable counter = 0.
  - dout = 0, rise = 0, fall = 0, glitch = 0, glitch_cnt = 0.
- Synchronizer: s is the output of the last stage of a SYNC_STAGES flop chain. The FSM sees only s, never din.
- Stable counter: width $clog2(MIN_WIDTH+1).
- FSM states: ST_LO, ST_PEND_HI, ST_HI, ST_PEND_LO.
  - ST_LO, s=1: go to ST_PEND_HI, cnt=1.
  - ST_LO, s=0: stay.
  - ST_PEND_HI, s=1 and cnt==MIN_WIDTH-1: go to ST_HI, dout<=1, rise=1 for one cycle, cnt=0.
  - ST_PEND_HI, s=1 otherwise: cnt++.
  - ST_PEND_HI, s=0: go to ST_LO, glitch=1 for one cycle, cnt=0, dout stays 0.
  - ST_HI, ST_PEND_LO: mirror image of the above, using fall instead of rise.
- Latency: dout changes on the edge of the MIN_WIDTH-th consecutive sample of s at the new level. din to dout is SYNC_STAGES+MIN_WIDTH cycles, +1 cycle of sampling uncertainty.
- A pulse whose synchronized width is 1 to MIN_WIDTH-1 samples produces exactly one glitch strobe and no dout change.
- A pulse narrower than one clock period may be missed entirely. No glitch is required in that case.
- Strobes: rise, fall and glitch are registered and mutually exclusive; at most one is high in any cycle.
- glitch_cnt:
  - Increments by 1 on each glitch strobe.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets it to 0 on the next edge and takes priority over a simultaneous glitch, so the result is 0.
- Reset mid-pending: the pending transition is discarded and no glitch is counted.
- Illegal state encodings recover to ST_LO with dout=0.

Decomposition:
- Package glitch_filter_pkg holds:
  - typedef enum logic [1:0] gf_state_t for the four states;
  - localparam GF_SYNC_MIN = 2.
- Sub-module sync_chain (parameter STAGES, ports clk, reset, d, q) implements the synchronizer and is reusable for other asynchronous inputs.
- The FSM, counter and strobes stay in glitch_filter.

Test Plan (defaults SYNC_STAGES=2, MIN_WIDTH=4, CNT_W=8; clk period 10 ns):
- Reset check: assert reset with din=1 held -> dout, rise, fall, glitch and glitch_cnt all 0 during reset. After release, dout rises exactly 6-7 cycles later with a single rise strobe.
- Clean edges: din 0->1 held 20 cycles, then 1->0 -> one rise, then dout=1 for about 20 cycles, one fall, glitch_cnt=0.
- Rejected pulses: drive din high for 25 ns (3 samples) from ST_LO -> dout stays 0, one glitch strobe, glitch_cnt=1. Then drive a high-level dropout of 15 ns in ST_HI -> dout stays 1, glitch_cnt=2.
- Hazard drive: connect the delayed SOP hazard circuit (inputs a=1, c toggling, b=0, d=1) to din, producing 2 ns spikes -> no glitch strobe is required and dout is stable at 1. Then stretch a spike to 30 ns -> exactly one glitch.
- Saturation and clear: inject 300 short pulses -> glitch_cnt stops at 255. Pulse clr_cnt in the same cycle as a glitch -> glitch_cnt=0.
- Reset mid-pending: drive din high for 2 samples, then assert reset -> state ST_LO, glitch_cnt unchanged at 0, no strobes.
